eth_phy_10g_tx_watchdog: RTL and testbench

ETH_PHY_10G_TX_WATCHDOG -- requirements
Module: eth_phy_10g_tx_watchdog

---
 rtl/eth_phy_10g_pkg.sv | 26 ++
 rtl/eth_phy_10g_window_timer.sv | 32 +++
 rtl/eth_phy_10g_tx_watchdog.sv | 164 ++++++++++++++++
 tb/tb_eth_phy_10g_tx_watchdog.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_phy_10g_pkg.sv
// Shared 10G PHY definitions: sync header codes, link FSM encoding and counter widths
// used by the TX and RX watchdogs.
package eth_phy_10g_pkg;

  localparam int unsigned HDR_W      = 2;
  localparam int unsigned LINK_CNT_W = 4;
  localparam int unsigned BAD_BLK_W  = 10;
  localparam int unsigned RST_CNT_W  = 8;

  localparam logic [HDR_W-1:0]      SYNC_DATA    = 2'b10;
  localparam logic [HDR_W-1:0]      SYNC_CTRL    = 2'b01;
  localparam logic [LINK_CNT_W-1:0] LINK_CNT_MAX = '1;
  localparam logic [BAD_BLK_W-1:0]  BAD_BLK_MAX  = '1;
  localparam logic [RST_CNT_W-1:0]  RST_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    DOWN    = 2'd0,
    UP      = 2'd1,
    HOLDOFF = 2'd2
  } link_state_e;

  function automatic logic sync_hdr_ok(input logic [HDR_W-1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_window_timer.sv
// Free-running down-counter that flags the last cycle of each COUNT+1 cycle window.
module eth_phy_10g_window_timer #(
  parameter int unsigned COUNT = 19531
) (
  input  logic clk,
  input  logic rst,
  output logic window_end
);

  localparam int unsigned CNT_W = (COUNT > 0) ? $clog2(COUNT + 1) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign window_end = (count_q == '0);

  always_comb begin
    count_d = count_q - CNT_W'(1);
    if (window_end) begin
      count_d = CNT_W'(COUNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CNT_W'(COUNT);
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/eth_phy_10g_tx_watchdog.sv
// TX link watchdog: grades each window on header, ready and error-block activity and
// walks DOWN/UP/HOLDOFF, requesting a SERDES TX reset after sustained bad windows.
module eth_phy_10g_tx_watchdog
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned HDR_WIDTH       = 2,
  parameter int unsigned COUNT_125US     = 19531,
  parameter int unsigned HOLDOFF_WINDOWS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HDR_WIDTH-1:0] serdes_tx_hdr,
  input  logic                 serdes_tx_hdr_valid,
  input  logic                 tx_bad_block,
  input  logic                 serdes_tx_ready,
  output logic                 serdes_tx_reset_req,
  output logic                 tx_status,
  output logic [7:0]           tx_reset_count
);

  if (HDR_WIDTH != HDR_W) begin : g_bad_hdr_width
    $error("eth_phy_10g_tx_watchdog: HDR_WIDTH must be 2");
  end

  localparam int unsigned HO_W = (HOLDOFF_WINDOWS > 1) ? $clog2(HOLDOFF_WINDOWS) : 1;

  logic                  window_end;
  logic                  hdr_bad_c;
  logic                  window_bad_c;
  logic                  holdoff_last_c;

  logic                  bad_hdr_q,   bad_hdr_d;
  logic                  not_ready_q, not_ready_d;
  logic [BAD_BLK_W-1:0]  bad_blk_q,   bad_blk_d;

  link_state_e           state_q;
  logic [LINK_CNT_W-1:0] good_cnt_q;
  logic [LINK_CNT_W-1:0] err_cnt_q;
  logic [HO_W-1:0]       holdoff_cnt_q;
  logic                  tx_status_q;
  logic                  reset_req_q;
  logic [RST_CNT_W-1:0]  reset_cnt_q;

  eth_phy_10g_window_timer #(
    .COUNT (COUNT_125US)
  ) u_window_timer (
    .clk        (clk),
    .rst        (rst),
    .window_end (window_end)
  );

  assign hdr_bad_c      = serdes_tx_hdr_valid && !sync_hdr_ok(HDR_W'(serdes_tx_hdr));
  assign window_bad_c   = bad_hdr_q || not_ready_q || (bad_blk_q == BAD_BLK_MAX);
  assign holdoff_last_c = (32'(holdoff_cnt_q) + 32'd1) >= HOLDOFF_WINDOWS;

  // Terminal-cycle inputs are dropped: flags restart clean for the next window.
  always_comb begin
    bad_hdr_d   = bad_hdr_q;
    not_ready_d = not_ready_q;
    bad_blk_d   = bad_blk_q;
    if (window_end) begin
      bad_hdr_d   = 1'b0;
      not_ready_d = 1'b0;
      bad_blk_d   = '0;
    end else begin
      bad_hdr_d   = bad_hdr_q || hdr_bad_c;
      not_ready_d = not_ready_q || !serdes_tx_ready;
      if (tx_bad_block && (bad_blk_q != BAD_BLK_MAX)) begin
        bad_blk_d = bad_blk_q + BAD_BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_hdr_q   <= 1'b0;
      not_ready_q <= 1'b0;
      bad_blk_q   <= '0;
    end else begin
      bad_hdr_q   <= bad_hdr_d;
      not_ready_q <= not_ready_d;
      bad_blk_q   <= bad_blk_d;
    end
  end

  // Link FSM; tx_status and the reset request are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= DOWN;
      good_cnt_q    <= '0;
      err_cnt_q     <= '0;
      holdoff_cnt_q <= '0;
      tx_status_q   <= 1'b0;
      reset_req_q   <= 1'b0;
      reset_cnt_q   <= '0;
    end else begin
      reset_req_q <= 1'b0;
      case (state_q)
        DOWN: begin
          if (window_end) begin
            if (!window_bad_c) begin
              err_cnt_q <= '0;
              if (good_cnt_q == LINK_CNT_MAX) begin
                state_q     <= UP;
                tx_status_q <= 1'b1;
              end else begin
                good_cnt_q <= good_cnt_q + LINK_CNT_W'(1);
              end
            end else begin
              good_cnt_q <= '0;
              if (err_cnt_q == LINK_CNT_MAX) begin
                state_q       <= HOLDOFF;
                err_cnt_q     <= '0;
                holdoff_cnt_q <= '0;
                reset_req_q   <= 1'b1;
                if (reset_cnt_q != RST_CNT_MAX) begin
                  reset_cnt_q <= reset_cnt_q + RST_CNT_W'(1);
                end
              end else begin
                err_cnt_q <= err_cnt_q + LINK_CNT_W'(1);
              end
            end
          end
        end
        UP: begin
          // A ready drop takes priority over a coincident window verdict.
          if (!serdes_tx_ready) begin
            state_q     <= DOWN;
            tx_status_q <= 1'b0;
            good_cnt_q  <= '0;
            err_cnt_q   <= '0;
          end else if (window_end && window_bad_c) begin
            state_q     <= DOWN;
            tx_status_q <= 1'b0;
            good_cnt_q  <= '0;
            err_cnt_q   <= LINK_CNT_W'(1);
          end
        end
        HOLDOFF: begin
          if (window_end) begin
            if (holdoff_last_c) begin
              state_q    <= DOWN;
              good_cnt_q <= '0;
              err_cnt_q  <= '0;
            end else begin
              holdoff_cnt_q <= holdoff_cnt_q + HO_W'(1);
            end
          end
        end
        default: begin
          state_q     <= DOWN;
          tx_status_q <= 1'b0;
          good_cnt_q  <= '0;
          err_cnt_q   <= '0;
        end
      endcase
    end
  end

  assign serdes_tx_reset_req = reset_req_q;
  assign tx_status           = tx_status_q;
  assign tx_reset_count      = reset_cnt_q;

endmodule

// File: tb/tb_eth_phy_10g_tx_watchdog.sv
// Bench for the TX watchdog: a table of window scenarios feeds a scoreboard checked at
// each window end, plus direct sequences for ready drop, async reset and saturation.
module tb_eth_phy_10g_tx_watchdog;

  localparam int unsigned WIN     = 16;
  localparam int unsigned WIN_BIG = 1024;

  typedef enum {K_GOOD, K_BADHDR, K_TERM, K_BB, K_NREADY, K_RESET} kind_e;

  typedef struct {
    kind_e      kind;
    int         n;
    logic       exp_status;
    logic       exp_req;
    int         exp_cnt;
  } row_t;

  typedef struct {
    int         win;
    logic       st;
    logic       req;
    int         cnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] hdr;
  logic       valid;
  logic       bb;
  logic       ready;
  logic       reset_req;
  logic       status;
  logic [7:0] rcount;

  logic       rst2;
  logic [1:0] hdr2;
  logic       bb2;
  logic       reset_req2;
  logic       status2;
  logic [7:0] rcount2;

  int   tests;
  int   fails;
  int   edge_cnt;
  int   cur_win;
  int   req_seen;
  exp_t sb_q[$];
  row_t rows[16];

  eth_phy_10g_tx_watchdog #(
    .HDR_WIDTH       (2),
    .COUNT_125US     (WIN - 1),
    .HOLDOFF_WINDOWS (2)
  ) u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .serdes_tx_hdr       (hdr),
    .serdes_tx_hdr_valid (valid),
    .tx_bad_block        (bb),
    .serdes_tx_ready     (ready),
    .serdes_tx_reset_req (reset_req),
    .tx_status           (status),
    .tx_reset_count      (rcount)
  );

  eth_phy_10g_tx_watchdog #(
    .HDR_WIDTH       (2),
    .COUNT_125US     (WIN_BIG - 1),
    .HOLDOFF_WINDOWS (2)
  ) u_dut_big (
    .clk                 (clk),
    .rst                 (rst2),
    .serdes_tx_hdr       (hdr2),
    .serdes_tx_hdr_valid (1'b1),
    .tx_bad_block        (bb2),
    .serdes_tx_ready     (1'b1),
    .serdes_tx_reset_req (reset_req2),
    .tx_status           (status2),
    .tx_reset_count      (rcount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  // Scoreboard: compare at the negedge following every window-end edge.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    if (!rst && edge_cnt != 0 && (edge_cnt % WIN) == 0) begin
      idx = edge_cnt / WIN;
      if (sb_q.size() > 0 && sb_q[0].win < idx) begin
        e = sb_q.pop_front();
        chk("sb_missed_window", 32'(idx), 32'(e.win));
      end
      if (sb_q.size() > 0 && sb_q[0].win == idx) begin
        e = sb_q.pop_front();
        chk($sformatf("w%0d_status", idx), 32'(status), 32'(e.st));
        chk($sformatf("w%0d_reset_req", idx), 32'(reset_req), 32'(e.req));
        chk($sformatf("w%0d_reset_count", idx), 32'(rcount), 32'(e.cnt));
      end
    end
    if (reset_req) req_seen++;
  end

  task automatic drive_window(input kind_e k);
    for (int j = 1; j <= int'(WIN); j++) begin
      valid = 1'b1;
      hdr   = (j % 2 == 1) ? 2'b10 : 2'b01;
      ready = 1'b1;
      bb    = 1'b0;
      if (j % 4 == 3) begin
        valid = 1'b0;
        hdr   = 2'b00;
      end
      case (k)
        K_BADHDR: if (j == 8) begin valid = 1'b1; hdr = 2'b11; end
        K_TERM:   if (j == int'(WIN)) begin valid = 1'b1; hdr = 2'b11; bb = 1'b1; end
        K_BB:     bb = 1'b1;
        K_NREADY: if (j == 5) ready = 1'b0;
        default:  ;
      endcase
      if (k == K_NREADY && j == 5) chk("status_before_drop", 32'(status), 32'd1);
      @(negedge clk);
      if (k == K_NREADY && j == 5) chk("status_after_drop", 32'(status), 32'd0);
    end
    cur_win++;
  endtask

  task automatic drive_partial(input int cycles);
    for (int j = 1; j <= cycles; j++) begin
      valid = 1'b1;
      hdr   = (j % 2 == 1) ? 2'b10 : 2'b01;
      ready = 1'b1;
      bb    = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    tests = 0; fails = 0; cur_win = 0; req_seen = 0;
    rst = 1'b0; rst2 = 1'b0;
    hdr = 2'b10; valid = 1'b1; bb = 1'b0; ready = 1'b1;
    hdr2 = 2'b10; bb2 = 1'b0;

    rows[0]  = '{K_GOOD,   15, 1'b0, 1'b0, 0};
    rows[1]  = '{K_GOOD,    1, 1'b1, 1'b0, 0};
    rows[2]  = '{K_BB,      1, 1'b1, 1'b0, 0};
    rows[3]  = '{K_TERM,    1, 1'b1, 1'b0, 0};
    rows[4]  = '{K_NREADY,  1, 1'b0, 1'b0, 0};
    rows[5]  = '{K_GOOD,   15, 1'b0, 1'b0, 0};
    rows[6]  = '{K_GOOD,    1, 1'b1, 1'b0, 0};
    rows[7]  = '{K_BADHDR,  1, 1'b0, 1'b0, 0};
    rows[8]  = '{K_RESET,   0, 1'b0, 1'b0, 0};
    rows[9]  = '{K_BADHDR, 15, 1'b0, 1'b0, 0};
    rows[10] = '{K_BADHDR,  1, 1'b0, 1'b1, 1};
    rows[11] = '{K_BADHDR,  1, 1'b0, 1'b0, 1};
    rows[12] = '{K_BADHDR,  1, 1'b0, 1'b0, 1};
    rows[13] = '{K_BADHDR, 15, 1'b0, 1'b0, 1};
    rows[14] = '{K_BADHDR,  1, 1'b0, 1'b1, 2};
    rows[15] = '{K_GOOD,    1, 1'b0, 1'b0, 2};

    #1;
    rst = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_req", 32'(reset_req), 32'd0);
    chk("reset_count", 32'(rcount), 32'd0);
    rst = 1'b0;

    for (int r = 0; r < 16; r++) begin
      if (rows[r].kind == K_RESET) begin
        drive_partial(7);
        rst = 1'b1;
        #1;
        chk("midwin_rst_status", 32'(status), 32'd0);
        chk("midwin_rst_req", 32'(reset_req), 32'd0);
        chk("midwin_rst_count", 32'(rcount), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cur_win = 0;
      end else begin
        for (int i = 0; i < rows[r].n; i++) begin
          if (i == rows[r].n - 1) begin
            e = '{cur_win + 1, rows[r].exp_status, rows[r].exp_req, rows[r].exp_cnt};
            sb_q.push_back(e);
          end
          drive_window(rows[r].kind);
        end
      end
    end

    // Asynchronous reset in the middle of a HOLDOFF window, away from any clock edge.
    drive_partial(5);
    chk("holdoff_count_pre_rst", 32'(rcount), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("holdoff_rst_status", 32'(status), 32'd0);
    chk("holdoff_rst_req", 32'(reset_req), 32'd0);
    chk("holdoff_rst_count", 32'(rcount), 32'd0);
    chk("total_reset_pulses", 32'(req_seen), 32'd2);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    // Large window: 1023 counted error blocks saturate and fail the window.
    @(negedge clk);
    rst2 = 1'b0;
    for (int c = 1; c <= 16 * int'(WIN_BIG); c++) begin
      hdr2 = (c % 2 == 1) ? 2'b10 : 2'b01;
      if (c == 16 * int'(WIN_BIG)) chk("big_status_pre_up", 32'(status2), 32'd0);
      @(negedge clk);
    end
    chk("big_status_up", 32'(status2), 32'd1);
    for (int c = 1; c <= int'(WIN_BIG); c++) begin
      hdr2 = (c % 2 == 1) ? 2'b10 : 2'b01;
      bb2  = 1'b1;
      if (c == int'(WIN_BIG)) chk("big_status_before_sat", 32'(status2), 32'd1);
      @(negedge clk);
    end
    bb2 = 1'b0;
    chk("big_status_sat_drop", 32'(status2), 32'd0);
    chk("big_reset_count", 32'(rcount2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
